// File: rtl/fs_pkg.sv
// Shared types and helpers for the pipelined ripple-borrow subtractor.
package fs_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 24;

  // Per-stage control bundle; the resolved diff bits live beside it because their width grows per stage.
  typedef struct packed {
    logic vld;
    logic borrow;
    logic zero;
  } fs_ctl_t;

  function automatic int fs_stages(input int width, input int slice);
    return (width + slice - 1) / slice;
  endfunction

endpackage

// File: rtl/fs_slice.sv
// Combinational W-bit ripple-borrow subtractor built from single-bit full-subtractor cells.
module fs_cell (
  input  logic i_x,
  input  logic i_y,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);
  assign o_d    = i_x ^ i_y ^ i_bin;
  assign o_bout = (~i_x & i_y) | (~(i_x ^ i_y) & i_bin);
endmodule

module fs_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  input  logic         i_cin,
  output logic [W-1:0] o_out,
  output logic         o_cout,
  output logic         o_zero
);
  logic [W:0] w_b;

  assign w_b[0] = i_cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    fs_cell u_cell (
      .i_x   (i_x[i]),
      .i_y   (i_y[i]),
      .i_bin (w_b[i]),
      .o_d   (o_out[i]),
      .o_bout(w_b[i+1])
    );
  end

  assign o_cout = w_b[W];
  assign o_zero = (o_out == '0);
endmodule

// File: rtl/fs_pipe.sv
// Pipelined a-b-bin, one SLICE_WIDTH slice per stage; latency STAGES (+1 with FS_PIPE_ABS_EN: |diff| and neg).
// Stage load = !valid || downstream load, so stalls hold data in place and in_ready is stage 0's load.
module fs_pipe
  import fs_pkg::*;
#(
  parameter int DATA_WIDTH  = MANT_W,
  parameter int SLICE_WIDTH = EXP_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic                  i_bin,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_diff,
  output logic                  o_bout,
  output logic                  o_zero
`ifdef FS_PIPE_ABS_EN
  ,
  output logic                  o_neg
`endif
);

  localparam int STAGES = fs_stages(DATA_WIDTH, SLICE_WIDTH);
  localparam int LAST   = STAGES - 1;

  logic w_tail_load;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * SLICE_WIDTH;
    localparam int HI = (k == LAST) ? DATA_WIDTH : LO + SLICE_WIDTH;
    localparam int W  = HI - LO;

    fs_ctl_t       r_ctl;
    logic [HI-1:0] r_diff;
    logic [HI-1:0] w_diff_nxt;
    logic [W-1:0]  w_x;
    logic [W-1:0]  w_y;
    logic [W-1:0]  w_out;
    logic          w_cin;
    logic          w_cout;
    logic          w_szero;
    logic          w_prev_vld;
    logic          w_prev_zero;
    logic          w_down_load;
    logic          w_load;
    logic          w_take;

    if (k == 0) begin : g_src
      assign w_prev_vld  = i_in_valid;
      assign w_prev_zero = 1'b1;
      assign w_cin       = i_bin;
      assign w_x         = i_a[HI-1:LO];
      assign w_y         = i_b[HI-1:LO];
      assign w_diff_nxt  = w_out;
    end else begin : g_src
      // Operands for this slice were skew-carried by the previous stage.
      assign w_prev_vld  = g_st[k-1].r_ctl.vld;
      assign w_prev_zero = g_st[k-1].r_ctl.zero;
      assign w_cin       = g_st[k-1].r_ctl.borrow;
      assign w_x         = g_st[k-1].g_hi.r_a[HI-1:LO];
      assign w_y         = g_st[k-1].g_hi.r_b[HI-1:LO];
      assign w_diff_nxt  = {w_out, g_st[k-1].r_diff};
    end

    if (k == LAST) begin : g_dn
      assign w_down_load = w_tail_load;
    end else begin : g_dn
      assign w_down_load = g_st[k+1].w_load;
    end

    assign w_load = !r_ctl.vld || w_down_load;
    assign w_take = w_load && w_prev_vld;

    fs_slice #(.W(W)) u_slice (
      .i_x   (w_x),
      .i_y   (w_y),
      .i_cin (w_cin),
      .o_out (w_out),
      .o_cout(w_cout),
      .o_zero(w_szero)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_ctl  <= '0;
        r_diff <= '0;
      end else if (w_load) begin
        r_ctl.vld <= w_prev_vld;
        if (w_prev_vld) begin
          r_ctl.borrow <= w_cout;
          r_ctl.zero   <= w_prev_zero & w_szero;
          r_diff       <= w_diff_nxt;
        end
      end
    end

    if (HI < DATA_WIDTH) begin : g_hi
      logic [DATA_WIDTH-1:HI] r_a;
      logic [DATA_WIDTH-1:HI] r_b;
      logic [DATA_WIDTH-1:HI] w_a_nxt;
      logic [DATA_WIDTH-1:HI] w_b_nxt;

      if (k == 0) begin : g_hsrc
        assign w_a_nxt = i_a[DATA_WIDTH-1:HI];
        assign w_b_nxt = i_b[DATA_WIDTH-1:HI];
      end else begin : g_hsrc
        assign w_a_nxt = g_st[k-1].g_hi.r_a[DATA_WIDTH-1:HI];
        assign w_b_nxt = g_st[k-1].g_hi.r_b[DATA_WIDTH-1:HI];
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_take) begin
          r_a <= w_a_nxt;
          r_b <= w_b_nxt;
        end
      end
    end
  end

  assign o_in_ready = g_st[0].w_load;

`ifdef FS_PIPE_ABS_EN
  logic                  r_abs_vld;
  logic                  r_abs_bout;
  logic                  r_abs_zero;
  logic [DATA_WIDTH-1:0] r_abs_diff;
  logic [DATA_WIDTH-1:0] w_raw;
  logic [DATA_WIDTH-1:0] w_mag;
  logic                  w_last_vld;
  logic                  w_last_bout;

  assign w_last_vld  = g_st[LAST].r_ctl.vld;
  assign w_last_bout = g_st[LAST].r_ctl.borrow;
  assign w_raw       = g_st[LAST].r_diff;
  // A borrow-out means the raw result wrapped, so two's-complement negate it back to a magnitude.
  assign w_mag       = w_last_bout ? (~w_raw + DATA_WIDTH'(1)) : w_raw;
  assign w_tail_load = !r_abs_vld || i_out_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_abs_vld  <= 1'b0;
      r_abs_bout <= 1'b0;
      r_abs_zero <= 1'b0;
      r_abs_diff <= '0;
    end else if (w_tail_load) begin
      r_abs_vld <= w_last_vld;
      if (w_last_vld) begin
        r_abs_bout <= w_last_bout;
        r_abs_zero <= g_st[LAST].r_ctl.zero;
        r_abs_diff <= w_mag;
      end
    end
  end

  assign o_out_valid = r_abs_vld;
  assign o_diff      = r_abs_diff;
  assign o_bout      = r_abs_bout;
  assign o_zero      = r_abs_zero;
  assign o_neg       = r_abs_bout;
`else
  assign w_tail_load = i_out_ready;
  assign o_out_valid = g_st[LAST].r_ctl.vld;
  assign o_diff      = g_st[LAST].r_diff;
  assign o_bout      = g_st[LAST].r_ctl.borrow;
  assign o_zero      = g_st[LAST].r_ctl.zero;
`endif

endmodule
